perceptron_train_ctrl: RTL and testbench

//  Sequences one online-training step of a single perceptron: drives the sample, waits out forward latency,

---
 rtl/perceptron_train_ctrl_pkg.sv | 47 ++++
 rtl/perceptron_train_ctrl_if.sv | 28 ++
 rtl/perceptron_train_ctrl_mult.sv | 10 +
 rtl/perceptron_train_ctrl.sv | 161 ++++++++++++++++
 tb/tb_perceptron_train_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_train_ctrl_pkg.sv
// Shared definitions for the perceptron training controller: state encoding,
// default Q-format parameters and saturating fixed-point helpers.
package perceptron_train_ctrl_pkg;

  localparam int unsigned DEF_NUM     = 2;
  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_FRAC    = 16;
  localparam int unsigned DEF_FWD_LAT = 2;
  localparam logic [31:0] DEF_LR      = 32'h0000_8000;

  // Wide enough to hold any full product plus carry for WIDTH up to 63.
  localparam int unsigned ACC_W = 128;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_ERR,
    ST_UPD,
    ST_WR,
    ST_DONE
  } state_e;

  function automatic acc_t q_one(input int unsigned frac);
    return acc_t'(1) <<< frac;
  endfunction

  function automatic acc_t q_maxv(input int unsigned w);
    return (acc_t'(1) <<< (w - 1)) - acc_t'(1);
  endfunction

  function automatic acc_t q_minv(input int unsigned w);
    return -(acc_t'(1) <<< (w - 1));
  endfunction

  // Clamp to the signed w-bit range instead of wrapping.
  function automatic acc_t sat_w(input acc_t x, input int unsigned w);
    if (x > q_maxv(w)) return q_maxv(w);
    if (x < q_minv(w)) return q_minv(w);
    return x;
  endfunction

  function automatic acc_t sat_add(input acc_t a, input acc_t b, input int unsigned w);
    return sat_w(a + b, w);
  endfunction

endpackage

// File: rtl/perceptron_train_ctrl_if.sv
// Sample/target source and perceptron-side signals of the training controller.
interface perceptron_train_ctrl_if #(
  parameter int unsigned NUM   = 2,
  parameter int unsigned WIDTH = 32
);
  logic                     i_start;
  logic [NUM*WIDTH-1:0]     i_k;
  logic [WIDTH-1:0]         i_t;
  logic [WIDTH-1:0]         i_a;
  logic [NUM*WIDTH-1:0]     i_w;
  logic [WIDTH-1:0]         i_b;
  logic [NUM*WIDTH-1:0]     o_k;
  logic                     o_wr;
  logic [(NUM+1)*WIDTH-1:0] o_w_new;
  logic [WIDTH-1:0]         o_err;
  logic                     o_busy;
  logic                     o_done;

  modport master (
    output i_start, i_k, i_t, i_a, i_w, i_b,
    input  o_k, o_wr, o_w_new, o_err, o_busy, o_done
  );

  modport slave (
    input  i_start, i_k, i_t, i_a, i_w, i_b,
    output o_k, o_wr, o_w_new, o_err, o_busy, o_done
  );
endinterface

// File: rtl/perceptron_train_ctrl_mult.sv
// Signed WIDTH x WIDTH multiplier with full 2*WIDTH product.
module mult_2in #(
  parameter int unsigned WIDTH = 32
) (
  input  logic signed [WIDTH-1:0]   i_a,
  input  logic signed [WIDTH-1:0]   i_b,
  output logic signed [2*WIDTH-1:0] o_p
);
  assign o_p = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);
endmodule

// File: rtl/perceptron_train_ctrl.sv
// One online-training step of a perceptron: capture sample, wait forward latency,
// form delta = LR*(t-a), update weights and bias serially through one multiplier.
module perceptron_train_ctrl
  import perceptron_train_ctrl_pkg::*;
#(
  parameter int unsigned      NUM     = DEF_NUM,
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter int unsigned      FRAC    = DEF_FRAC,
  parameter int unsigned      FWD_LAT = DEF_FWD_LAT,
  parameter logic [WIDTH-1:0] LR      = WIDTH'(DEF_LR)
) (
  input logic                    clk,
  input logic                    rst,
  perceptron_train_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FWD_LAT + NUM + 2);
  typedef logic signed [WIDTH-1:0] data_t;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM*WIDTH-1:0]     k_q, k_d;
  data_t                    t_q, t_d;
  data_t                    w_q [NUM];
  data_t                    w_d [NUM];
  data_t                    b_q, b_d;
  data_t                    delta_q, delta_d;
  data_t                    err_q, err_d;
  logic [(NUM+1)*WIDTH-1:0] wnew_q, wnew_d;
  logic                     wr_q, wr_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  data_t                    mul_a, mul_b, err_c, scaled_c;
  logic signed [2*WIDTH-1:0] prod;

  // ERR multiplies LR by the fresh error; UPD multiplies delta by k[idx].
  always_comb begin
    mul_a = delta_q;
    mul_b = '0;
    for (int i = 0; i < int'(NUM); i++) begin
      if (cnt_q == CNT_W'(i)) mul_b = data_t'(k_q[i*WIDTH +: WIDTH]);
    end
    if (state_q == ST_ERR) begin
      mul_a = data_t'(LR);
      mul_b = err_c;
    end
  end

  mult_2in #(.WIDTH(WIDTH)) u_mult (
    .i_a (mul_a),
    .i_b (mul_b),
    .o_p (prod)
  );

  assign err_c    = WIDTH'(sat_w(acc_t'(t_q) - acc_t'($signed(bus.i_a)), WIDTH));
  assign scaled_c = WIDTH'(sat_w(acc_t'(prod >>> FRAC), WIDTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    t_d     = t_q;
    b_d     = b_q;
    delta_d = delta_q;
    err_d   = err_q;
    wnew_d  = wnew_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    for (int i = 0; i < int'(NUM); i++) w_d[i] = w_q[i];

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          k_d     = bus.i_k;
          t_d     = data_t'(bus.i_t);
          cnt_d   = '0;
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        if (cnt_q == CNT_W'(FWD_LAT - 1)) begin
          for (int i = 0; i < int'(NUM); i++) w_d[i] = data_t'(bus.i_w[i*WIDTH +: WIDTH]);
          b_d     = data_t'(bus.i_b);
          cnt_d   = '0;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR: begin
        err_d   = err_c;
        delta_d = scaled_c;
        cnt_d   = '0;
        state_d = ST_UPD;
      end
      ST_UPD: begin
        for (int i = 0; i < int'(NUM); i++) begin
          if (cnt_q == CNT_W'(i)) w_d[i] = WIDTH'(sat_add(acc_t'(w_q[i]), acc_t'(scaled_c), WIDTH));
        end
        if (cnt_q == CNT_W'(NUM)) begin
          // Bias input is implicitly 1.0, so delta is added directly.
          b_d = WIDTH'(sat_add(acc_t'(b_q), acc_t'(delta_q), WIDTH));
          for (int i = 0; i < int'(NUM); i++) wnew_d[i*WIDTH +: WIDTH] = w_d[i];
          wnew_d[NUM*WIDTH +: WIDTH] = b_d;
          wr_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_WR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      t_q     <= '0;
      b_q     <= '0;
      delta_q <= '0;
      err_q   <= '0;
      wnew_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < int'(NUM); i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      t_q     <= t_d;
      b_q     <= b_d;
      delta_q <= delta_d;
      err_q   <= err_d;
      wnew_q  <= wnew_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      for (int i = 0; i < int'(NUM); i++) w_q[i] <= w_d[i];
    end
  end

  assign bus.o_k     = k_q;
  assign bus.o_wr    = wr_q;
  assign bus.o_w_new = wnew_q;
  assign bus.o_err   = err_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench for perceptron_train_ctrl: cycle-level model of one training
// step checked every cycle, plus hand-computed results for the key scenarios.
module tb_perceptron_train_ctrl;

  localparam int NUM      = 2;
  localparam int WIDTH    = 32;
  localparam int FRAC     = 16;
  localparam int FWD_LAT  = 2;
  localparam int WR_CYC   = FWD_LAT + NUM + 3;
  localparam int DONE_CYC = WR_CYC + 1;
  localparam longint LR_V = 64'sh8000;
  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  perceptron_train_ctrl_if #(.NUM(NUM), .WIDTH(WIDTH)) bus ();

  perceptron_train_ctrl #(
    .NUM(NUM), .WIDTH(WIDTH), .FRAC(FRAC), .FWD_LAT(FWD_LAT), .LR(32'h0000_8000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic longint clamp(input longint x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic longint s32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  // Model: phase counts cycles since the accepted start (-1 = idle).
  int                   m_phase = -1;
  logic [NUM*32-1:0]    m_k = '0;
  longint               m_t, m_b, m_e, m_d;
  longint               m_w [NUM];
  logic [31:0]          m_err = '0;
  logic [(NUM+1)*32-1:0] m_wnew = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = -1;
      m_k     = '0;
      m_err   = '0;
      m_wnew  = '0;
    end else if (m_phase < 0) begin
      if (bus.i_start) begin
        m_phase = 1;
        m_k     = bus.i_k;
        m_t     = s32(bus.i_t);
      end
    end else begin
      if (m_phase == FWD_LAT) begin
        for (int i = 0; i < NUM; i++) m_w[i] = s32(bus.i_w[i*32 +: 32]);
        m_b = s32(bus.i_b);
      end
      if (m_phase == FWD_LAT + 1) begin
        m_e   = clamp(m_t - s32(bus.i_a));
        m_d   = clamp((LR_V * m_e) >>> FRAC);
        m_err = 32'(m_e);
        for (int i = 0; i < NUM; i++) begin
          m_w[i] = clamp(m_w[i] + clamp((m_d * s32(m_k[i*32 +: 32])) >>> FRAC));
          m_wnew[i*32 +: 32] = 32'(m_w[i]);
        end
        m_b = clamp(m_b + m_d);
        m_wnew[NUM*32 +: 32] = 32'(m_b);
      end
      m_phase = (m_phase == DONE_CYC) ? -1 : m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_o_busy", bus.o_busy, m_phase >= 1);
      check("cyc_o_wr", bus.o_wr, m_phase == WR_CYC);
      check("cyc_o_done", bus.o_done, m_phase == DONE_CYC);
      check("cyc_o_k", bus.o_k, m_k);
      check("cyc_o_err", bus.o_err, m_err);
      if (m_phase == WR_CYC) check("cyc_o_w_new", bus.o_w_new, m_wnew);
    end
  end

  task automatic set_inputs(input logic [31:0] k1, k0, t, a, w1, w0, b);
    bus.i_k = {k1, k0};
    bus.i_t = t;
    bus.i_a = a;
    bus.i_w = {w1, w0};
    bus.i_b = b;
  endtask

  // Called at a negedge: start is sampled at the next posedge (cycle 0).
  task automatic start_step();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_wr(output int cyc);
    cyc = 1;
    while (!bus.o_wr && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_o_k"}, bus.o_k, '0);
    check({tag, "_o_w_new"}, bus.o_w_new, '0);
    check({tag, "_o_err"}, bus.o_err, '0);
    check({tag, "_o_wr"}, bus.o_wr, 1'b0);
    check({tag, "_o_busy"}, bus.o_busy, 1'b0);
    check({tag, "_o_done"}, bus.o_done, 1'b0);
  endtask

  initial begin
    int c;
    int n_wr;
    logic [95:0] seen;
    bus.i_start = 1'b0;
    set_inputs('0, '0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Nominal step: k={2.0,1.0}, t=1.0, a=0.5, w={0.5,0.25}, b=0.125.
    set_inputs(32'h2_0000, 32'h1_0000, 32'h1_0000, 32'h8000, 32'h8000, 32'h4000, 32'h2000);
    start_step();
    wait_wr(c);
    check("nom_wr_cycle", 32'(c), 32'd7);
    check("nom_w_new", bus.o_w_new, {32'h6000, 32'h1_0000, 32'h8000});
    check("nom_err", bus.o_err, 32'h8000);
    @(negedge clk);
    check("nom_done", bus.o_done, 1'b1);
    @(negedge clk);
    check("nom_idle_busy", bus.o_busy, 1'b0);

    // Zero error leaves parameters unchanged but still writes once.
    set_inputs(32'h3_0000, 32'h1_8000, 32'hC000, 32'hC000, 32'h1_2345, 32'hFFFF_8000, 32'h7000);
    start_step();
    n_wr = 0;
    seen = '0;
    for (int j = 1; j <= 10; j++) begin
      if (bus.o_wr) begin
        n_wr++;
        seen = bus.o_w_new;
      end
      @(negedge clk);
    end
    check("zero_wr_count", 32'(n_wr), 32'd1);
    check("zero_w_new", seen, {32'h7000, 32'h1_2345, 32'hFFFF_8000});
    check("zero_err", bus.o_err, 32'h0);

    // Positive saturation of w0.
    set_inputs(32'h0, 32'h64_0000, 32'h1_0000, 32'h0, 32'h0, 32'h7FFF_0000, 32'h0);
    start_step();
    wait_wr(c);
    check("satp_wr_cycle", 32'(c), 32'd7);
    check("satp_w0", bus.o_w_new[31:0], 32'h7FFF_FFFF);
    check("satp_w_new", bus.o_w_new, {32'h8000, 32'h0, 32'h7FFF_FFFF});
    repeat (2) @(negedge clk);

    // Negative saturation mirror.
    set_inputs(32'h0, 32'h64_0000, 32'h0, 32'h1_0000, 32'h0, 32'h8001_0000, 32'h0);
    start_step();
    wait_wr(c);
    check("satn_w0", bus.o_w_new[31:0], 32'h8000_0000);
    check("satn_w_new", bus.o_w_new, {32'hFFFF_8000, 32'h0, 32'h8000_0000});
    check("satn_err", bus.o_err, 32'hFFFF_0000);
    repeat (2) @(negedge clk);

    // Start held every cycle while the sample keeps changing.
    set_inputs(32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h4000, 32'h1000, 32'h2000, 32'h3000);
    bus.i_start = 1'b1;
    n_wr = 0;
    for (int j = 0; j < 27; j++) begin
      bus.i_k = {32'(j * 65536), 32'((j + 3) * 32768)};
      if (bus.o_wr) n_wr++;
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    check("busy_wr_count", 32'(n_wr), 32'd3);
    @(negedge clk);

    // Reset asserted during UPD abandons the step.
    set_inputs(32'h2_0000, 32'h1_0000, 32'h1_0000, 32'h8000, 32'h8000, 32'h4000, 32'h2000);
    start_step();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("rst_upd");
    n_wr = 0;
    for (int j = 0; j < 12; j++) begin
      if (bus.o_wr) n_wr++;
      @(negedge clk);
    end
    check("rst_upd_no_wr", 32'(n_wr), 32'd0);

    // Back-to-back: next start in the cycle after o_done.
    start_step();
    c = 1;
    while (!bus.o_done && c < 30) begin
      @(negedge clk);
      c++;
    end
    check("b2b_done_cycle", 32'(c), 32'd8);
    @(negedge clk);
    start_step();
    wait_wr(c);
    check("b2b_wr_cycle", 32'(c), 32'd7);
    check("b2b_w_new", bus.o_w_new, {32'h6000, 32'h1_0000, 32'h8000});
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected to finish");
    $fatal(1);
  end

endmodule
